ifetch_ctrl: RTL and testbench
==============================

Name: ifetch_ctrl

Overview:
Instruction-fetch sequencer for the LEGv8 core. It owns the fetch PC, drives the word address of the combinational instruction memory (imem: 64 x 32-bit, 6-bit word address), and buffers fetched words in a small queue. The queue feeds decode through a valid/ready handshake. The block sits between imem and the decode stage, and absorbs decode stalls and branch redirects.

Parameters:
DEPTH, 2, fetch-queue entries (power of two, >= 2)
RESET_PC, 64'h0, fetch PC loaded on reset

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
en  input  1  fetch enable; when 0, no new words are pushed
imem_addr  output  6  word address to imem, equals fetch_pc[7:2]
imem_q  input  32  imem read data, combinational from imem_addr
redirect  input  1  branch/exception redirect strobe
redirect_pc  input  64  redirect target, byte address
dec_valid  output  1  queue head holds a valid instruction
dec_ready  input  1  decode accepts head this cycle
dec_instr  output  32  head instruction; 0 when empty
dec_pc  output  64  head PC; 0 when empty

Behaviour:
- Reset (async, any time, including mid-operation):
  - fetch_pc = RESET_PC and the queue is emptied.
  - dec_valid=0, dec_instr=0, dec_pc=0, imem_addr=RESET_PC[7:2].
- imem is combinational. In cycle N the block samples imem_q for imem_addr = fetch_pc[7:2] of that cycle.
- Pop: dec_valid & dec_ready at a rising edge removes the head.
- Push condition at a rising edge: en & ~redirect & (count<DEPTH | pop).
  - A push enqueues {fetch_pc, imem_q} and sets fetch_pc += 4.
- Latency: the first edge after reset release pushes. dec_valid is high in the following cycle with pc=RESET_PC. Steady state is one instruction per cycle.
- Full (count==DEPTH), no pop: no push; fetch_pc and imem_addr hold.
- Full with pop: push and pop occur in the same edge; count is unchanged.
- Empty: dec_valid=0, dec_instr/dec_pc=0. dec_ready is ignored.
- Redirect (highest priority over push and pop):
  - At the edge, the queue is cleared (count=0), fetch_pc=redirect_pc, and there is no push.
  - A head presented in the redirect cycle may be accepted by decode; it is still discarded from the queue.
  - dec_valid=0 for exactly one cycle after the redirect edge. The next valid head has pc=redirect_pc.
- Wrap rules:
  - fetch_pc wraps modulo 2^64.
  - imem_addr uses only fetch_pc[7:2], so PC 0x100 maps to word 0.
  - fetch_pc[1:0] are carried unchanged; redirect_pc misalignment is not checked.
- en=0: no push; queued entries still drain to decode.
- The queue is a circular buffer with rd/wr pointers of log2(DEPTH) bits and a count of log2(DEPTH)+1 bits.
- Outputs are driven from registered queue storage; there is no combinational path from imem_q to dec_instr.

Decomposition:
- Package ifetch_pkg:
  - constants IMEM_AW=6, INSTR_W=32, PC_W=64
  - typedef fetch_entry_t {logic [PC_W-1:0] pc; logic [INSTR_W-1:0] instr;}
- Sub-module fetch_fifo:
  - parameterised by DEPTH, holds fetch_entry_t
  - ports: push, pop, clear, full, empty, head
  - clear has priority over push/pop
- ifetch_ctrl holds the PC register, push/redirect logic and the imem address mapping.

Test Plan (DEPTH=2, real imem contents):
1. Reset release, dec_ready=1, en=1 -> consecutive heads (pc,instr) = (0x0,f8000001), (0x4,f8008002), (0x8,f8000203), (0xC,8b050083), one per cycle.
2. dec_ready=0 for 5 cycles after reset -> count saturates at 2, imem_addr holds 2. On dec_ready=1 the heads f8000001, f8008002, f8000203 arrive back-to-back with no bubble.
3. Redirect to 0x0C while the queue is full -> dec_valid=0 for one cycle, then head (0xC,8b050083), then (0x10,f8018003).
4. Redirect to 0xFC -> head (0xFC,0x0) from word 63, then (0x100,f8000001) with imem_addr=0.
5. en=0 with 2 queued entries and dec_ready=1 -> two entries drain, dec_valid=0 afterwards, fetch_pc frozen. en=1 resumes at the next sequential PC.
6. Async reset asserted mid-cycle with the queue full -> dec_valid, dec_instr, dec_pc and imem_addr go to 0 immediately without a clock edge. After release, scenario 1 repeats exactly.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Contents: imem/instruction/PC widths, the fetch queue entry type and
// the byte-PC to imem word-address mapping.
package ifetch_pkg;

    localparam int unsigned IMEM_AW = 6;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_W    = 64;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // imem is word addressed and only 64 words deep, so upper PC bits alias.
    function automatic logic [IMEM_AW-1:0] imem_word(input logic [PC_W-1:0] pc);
        return pc[IMEM_AW+1:2];
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular fetch queue holding (pc, instr) entries.
// Ports:
//   clk, reset      clock, async active-high reset
//   push, din       enqueue din (ignored when full and not popping)
//   pop             dequeue head (ignored when empty)
//   clear           empty the queue; wins over push and pop
//   full, empty     occupancy flags
//   head            entry at the read pointer (stale when empty)
module fetch_fifo
    import ifetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         clear,
    input  fetch_entry_t din,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // A full queue can still accept when the head leaves on the same edge.
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    // Pointers and occupancy; pointers wrap naturally as DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Entry storage; contents are don't-care while unoccupied.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, addresses the
// combinational imem and queues fetched words for decode.
// Ports:
//   clk, reset                 clock, async active-high reset
//   en                         fetch enable (queue still drains when low)
//   imem_addr / imem_q         imem word address / read data
//   redirect, redirect_pc      branch/exception redirect strobe and target
//   dec_valid/dec_ready        decode handshake on the queue head
//   dec_instr, dec_pc          head entry, zero when the queue is empty
module ifetch_ctrl
    import ifetch_pkg::*;
#(
    parameter int unsigned    DEPTH    = 2,
    parameter logic [PC_W-1:0] RESET_PC = 64'h0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [INSTR_W-1:0] imem_q,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [INSTR_W-1:0] dec_instr,
    output logic [PC_W-1:0]    dec_pc
);

    logic [PC_W-1:0] fetch_pc;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    fetch_entry_t    din;
    fetch_entry_t    head;

    assign imem_addr = imem_word(fetch_pc);

    assign pop  = dec_valid & dec_ready;
    // Redirect suppresses the push; the FIFO clear also overrides the pop.
    assign push = en & ~redirect & (~full | pop);

    assign din.pc    = fetch_pc;
    assign din.instr = imem_q;

    // Head outputs come straight from queue storage, masked to zero when empty.
    assign dec_valid = ~empty;
    assign dec_instr = empty ? '0 : head.instr;
    assign dec_pc    = empty ? '0 : head.pc;

    // Fetch PC: redirect wins, otherwise advance one word per accepted push.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
        end else if (redirect) begin
            fetch_pc <= redirect_pc;
        end else if (push) begin
            fetch_pc <= fetch_pc + PC_W'(4);
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .clear (redirect),
        .din   (din),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed self-checking bench for ifetch_ctrl (DEPTH=2) with a small
// combinational imem model holding the LEGv8 program words.
module tb_ifetch_ctrl;

    logic        clk;
    logic        reset;
    logic        en;
    logic [5:0]  imem_addr;
    logic [31:0] imem_q;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [63:0] dec_pc;

    logic [31:0] imem [64];
    int          n_checks;
    int          n_errors;

    ifetch_ctrl #(
        .DEPTH   (2),
        .RESET_PC(64'h0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .imem_addr  (imem_addr),
        .imem_q     (imem_q),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .dec_valid  (dec_valid),
        .dec_ready  (dec_ready),
        .dec_instr  (dec_instr),
        .dec_pc     (dec_pc)
    );

    assign imem_q = imem[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One rising edge, then settle at the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_head(input string tag, input logic [63:0] pc, input logic [31:0] instr);
        check({tag, ".valid"}, 64'(dec_valid), 64'd1);
        check({tag, ".pc"},    dec_pc,         pc);
        check({tag, ".instr"}, 64'(dec_instr), 64'(instr));
    endtask

    task automatic expect_empty(input string tag);
        check({tag, ".valid"}, 64'(dec_valid), 64'd0);
        check({tag, ".pc"},    dec_pc,         64'd0);
        check({tag, ".instr"}, 64'(dec_instr), 64'd0);
    endtask

    // Reset release with en=1, dec_ready=1: one instruction per cycle.
    task automatic run_seq1(input string tag);
        en = 1'b1; dec_ready = 1'b1; redirect = 1'b0;
        reset = 1'b0;
        check({tag, ".first_empty"}, 64'(dec_valid), 64'd0);
        step(); expect_head({tag, ".h0"}, 64'h0, 32'hf8000001);
        step(); expect_head({tag, ".h1"}, 64'h4, 32'hf8008002);
        step(); expect_head({tag, ".h2"}, 64'h8, 32'hf8000203);
        step(); expect_head({tag, ".h3"}, 64'hC, 32'h8b050083);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 64; i++) imem[i] = {16'hA5A5, 16'(i)};
        imem[0]  = 32'hf8000001;
        imem[1]  = 32'hf8008002;
        imem[2]  = 32'hf8000203;
        imem[3]  = 32'h8b050083;
        imem[4]  = 32'hf8018003;
        imem[63] = 32'h00000000;

        reset = 1'b1; en = 1'b1; dec_ready = 1'b1;
        redirect = 1'b0; redirect_pc = 64'h0;
        step(); step();
        expect_empty("reset");
        check("reset.imem_addr", 64'(imem_addr), 64'd0);

        // 1: straight-line fetch
        run_seq1("s1");

        // 2: decode stalled after reset, queue saturates
        reset = 1'b1; dec_ready = 1'b0;
        step();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("s2.imem_addr_hold", 64'(imem_addr), 64'd2);
        expect_head("s2.h0", 64'h0, 32'hf8000001);
        dec_ready = 1'b1;
        step(); expect_head("s2.h1", 64'h4, 32'hf8008002);
        step(); expect_head("s2.h2", 64'h8, 32'hf8000203);

        // 3: redirect to 0xC with a full queue
        redirect = 1'b1; redirect_pc = 64'hC;
        step();
        redirect = 1'b0;
        check("s3.bubble", 64'(dec_valid), 64'd0);
        step(); expect_head("s3.h0", 64'hC,  32'h8b050083);
        step(); expect_head("s3.h1", 64'h10, 32'hf8018003);

        // 4: redirect to the last imem word, then alias to word 0
        redirect = 1'b1; redirect_pc = 64'hFC;
        step();
        redirect = 1'b0;
        check("s4.bubble", 64'(dec_valid), 64'd0);
        check("s4.addr63", 64'(imem_addr), 64'd63);
        step(); expect_head("s4.h0", 64'hFC, 32'h0);
        check("s4.addr_wrap", 64'(imem_addr), 64'd0);
        step(); expect_head("s4.h1", 64'h100, 32'hf8000001);

        // 5: fill to two entries, then drain with en=0
        dec_ready = 1'b0;
        step();
        en = 1'b0; dec_ready = 1'b1;
        expect_head("s5.h0", 64'h100, 32'hf8000001);
        step(); expect_head("s5.h1", 64'h104, 32'hf8008002);
        step(); expect_empty("s5.drained");
        check("s5.addr_frozen", 64'(imem_addr), 64'd2);
        step(); expect_empty("s5.still_empty");
        check("s5.addr_still", 64'(imem_addr), 64'd2);
        en = 1'b1;
        step(); expect_head("s5.resume", 64'h108, 32'hf8000203);

        // 6: async reset mid-cycle with the queue full
        dec_ready = 1'b0;
        step();
        check("s6.full_addr", 64'(imem_addr), 64'd4);
        check("s6.full_valid", 64'(dec_valid), 64'd1);
        #1 reset = 1'b1;
        #1;
        expect_empty("s6.async");
        check("s6.async_addr", 64'(imem_addr), 64'd0);
        @(negedge clk);
        step();
        run_seq1("s6.rerun");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
